// File: rtl/mem_bus_scheduler_if.sv
// Requester-side and memory-side signals of the shared 16-bit memory bus.
// master = scheduler view, slave = requesters/memory view.
interface mem_bus_scheduler_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ*19-1:0] req_m_addr;
  logic [NUM_REQ*16-1:0] req_m_data_out;
  logic [NUM_REQ-1:0]    req_m_access;
  logic [NUM_REQ-1:0]    req_m_wr_en;
  logic [NUM_REQ*2-1:0]  req_m_bytesel;
  logic [NUM_REQ-1:0]    req_m_lock;
  logic [15:0]           req_m_data_in;
  logic [NUM_REQ-1:0]    req_m_ack;
  logic [NUM_REQ-1:0]    req_m_err;
  logic [NUM_REQ-1:0]    grant;

  logic [18:0] q_m_addr;
  logic [15:0] q_m_data_in;
  logic [15:0] q_m_data_out;
  logic        q_m_access;
  logic        q_m_ack;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;

  modport master (
    input  req_m_addr, req_m_data_out, req_m_access, req_m_wr_en, req_m_bytesel, req_m_lock,
    output req_m_data_in, req_m_ack, req_m_err, grant,
    output q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel,
    input  q_m_data_in, q_m_ack
  );

  modport slave (
    output req_m_addr, req_m_data_out, req_m_access, req_m_wr_en, req_m_bytesel, req_m_lock,
    input  req_m_data_in, req_m_ack, req_m_err, grant,
    input  q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel,
    output q_m_data_in, q_m_ack
  );
endinterface

// File: rtl/mem_bus_scheduler.sv
// Round-robin owner selection for the shared memory bus, with a bus lock for
// read-modify-write sequences and an ack watchdog that aborts hung accesses.
module mem_bus_scheduler #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_bus_scheduler_if.master bus
);
  localparam int              IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam bit              WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam int              WDW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0]  WD_LAST  = WD_EN ? WDW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_REQ - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  // Assertion is immediate; release is aligned to clk.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_t               state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 lock_valid_q, lock_valid_d;
  logic [IW-1:0]        lock_owner_q, lock_owner_d;
  logic [WDW-1:0]       wd_q, wd_d;

  logic                 busy, timeout, done, lock_hold, pick, rr_any;
  logic [IW-1:0]        rr_win, rr_idx, pick_idx;
  logic [NUM_REQ-1:0]   ack_c, err_c;

  assign busy      = (state_q == BUSY);
  assign timeout   = WD_EN && busy && !bus.q_m_ack && (wd_q == WD_LAST);
  assign done      = busy && (bus.q_m_ack || timeout);
  assign lock_hold = lock_valid_q && bus.req_m_lock[lock_owner_q];

  // Descending scan so the nearest requester after rr_ptr wins.
  always_comb begin
    rr_win = '0;
    rr_any = 1'b0;
    rr_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      rr_idx = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (bus.req_m_access[rr_idx]) begin
        rr_win = rr_idx;
        rr_any = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    wd_d         = wd_q;
    ack_c        = '0;
    err_c        = '0;
    pick         = lock_hold ? bus.req_m_access[lock_owner_q] : rr_any;
    pick_idx     = lock_hold ? lock_owner_q : rr_win;
    case (state_q)
      IDLE: begin
        if (!lock_hold) lock_valid_d = 1'b0;
        if (pick) begin
          state_d = BUSY;
          owner_d = pick_idx;
          grant_d = NUM_REQ'(1) << pick_idx;
          wd_d    = '0;
        end
      end
      BUSY: begin
        if (done) begin
          ack_c[owner_q] = 1'b1;
          err_c[owner_q] = timeout;
          state_d        = IDLE;
          grant_d        = '0;
          rr_ptr_d       = owner_q;
          // An aborted access never keeps the lock.
          lock_valid_d   = bus.q_m_ack && bus.req_m_lock[owner_q];
          lock_owner_d   = owner_q;
        end else if (WD_EN) begin
          wd_d = wd_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= LAST_IDX;
      grant_q      <= '0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= '0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      wd_q         <= wd_d;
    end
  end

  logic [18:0] q_addr;
  logic [15:0] q_dout;
  logic        q_wr;
  logic [1:0]  q_bs;
  always_comb begin
    q_addr = '0;
    q_dout = '0;
    q_wr   = 1'b0;
    q_bs   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (busy && owner_q == IW'(i)) begin
        q_addr = bus.req_m_addr[i*19 +: 19];
        q_dout = bus.req_m_data_out[i*16 +: 16];
        q_wr   = bus.req_m_wr_en[i];
        q_bs   = bus.req_m_bytesel[i*2 +: 2];
      end
    end
  end

  assign bus.q_m_access    = busy;
  assign bus.q_m_addr      = q_addr;
  assign bus.q_m_data_out  = q_dout;
  assign bus.q_m_wr_en     = q_wr;
  assign bus.q_m_bytesel   = q_bs;
  assign bus.req_m_ack     = ack_c;
  assign bus.req_m_err     = err_c;
  assign bus.grant         = grant_q;
  assign bus.req_m_data_in = timeout ? 16'h0000 : bus.q_m_data_in;
endmodule

// File: doc/mem_bus_scheduler.md
Name: mem_bus_scheduler

Overview:
- N-way round-robin scheduler for the single shared 16-bit memory bus (19-bit word address).
- Serves instruction fetch, data load/store and a DMA/debug port; replaces fixed data-first priority with fair rotation.
- Adds a bus lock for read-modify-write sequences and an ack watchdog that terminates hung accesses with an error.
- Sits between the CPU/DMA master ports and the memory/IO decode.

Parameters:
- NUM_REQ, 3, number of requester ports; index 0 = data, 1 = instr, 2 = DMA. Legal range 2..8.
- TIMEOUT_CYCLES, 255, bus cycles without q_m_ack before a watchdog abort. 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req_m_addr  in  NUM_REQ*19  per-requester word address; requester i at [i*19 +: 19]
- req_m_data_out  in  NUM_REQ*16  per-requester write data
- req_m_access  in  NUM_REQ  access request; held until that requester's ack
- req_m_wr_en  in  NUM_REQ  1 = write
- req_m_bytesel  in  NUM_REQ*2  byte enables
- req_m_lock  in  NUM_REQ  retain bus ownership after the current access
- req_m_data_in  out  16  read data, broadcast to all requesters
- req_m_ack  out  NUM_REQ  one-hot, 1-cycle completion pulse
- req_m_err  out  NUM_REQ  1-cycle pulse, coincident with ack, on watchdog abort
- grant  out  NUM_REQ  registered one-hot current owner (debug/perf)
- q_m_addr  out  19  memory bus address
- q_m_data_in  in  16  memory read data
- q_m_data_out  out  16  memory write data
- q_m_access  out  1  memory access strobe
- q_m_ack  in  1  memory completion
- q_m_wr_en  out  1  write enable
- q_m_bytesel  out  2  byte enables

Behaviour:
- Reset (async assert, sync deassert):
  - q_m_access=0, q_m_wr_en=0, q_m_addr=0, q_m_bytesel=0, q_m_data_out=0.
  - All req_m_ack, req_m_err and grant = 0.
  - State = IDLE; rr_ptr = NUM_REQ-1, so requester 0 wins first; lock cleared; watchdog = 0.
  - Reset during BUSY aborts immediately; no ack or err is issued.
- FSM states: IDLE, BUSY.
- IDLE:
  - If any req_m_access is set, select the winner: first set bit searching from rr_ptr+1 modulo NUM_REQ.
  - Registered: grant, owner index, state <= BUSY. Latency is 1 cycle from access to q_m_access.
- BUSY:
  - q_m_access=1; q_m_addr, q_m_data_out, q_m_wr_en and q_m_bytesel are muxed from the owner.
  - req_m_ack[owner] = q_m_ack, combinational pass-through. req_m_data_in = q_m_data_in.
  - On q_m_ack: rr_ptr <= owner; state <= IDLE; grant <= 0; lock_valid <= req_m_lock[owner].
  - Minimum one idle bus cycle between accesses.
- Lock:
  - While lock_valid=1, IDLE grants only lock_owner and ignores all other requests.
  - lock_valid clears in IDLE when req_m_lock[lock_owner]=0.
  - A lock with no pending owner access stalls other requesters; this is intended.
- Watchdog, when TIMEOUT_CYCLES != 0:
  - Counter clears on entry to BUSY and increments each BUSY cycle without q_m_ack.
  - When it reaches TIMEOUT_CYCLES: pulse req_m_ack[owner] and req_m_err[owner] together; req_m_data_in forced to 16'h0000 that cycle; q_m_access drops next cycle; state <= IDLE; lock_valid <= 0.
  - q_m_ack on the same cycle as expiry: normal ack wins, no err.
  - A late q_m_ack after an abort, arriving while IDLE, is ignored.
- Outputs when not BUSY: q_m_access=0, q_m_wr_en=0, q_m_bytesel=0, q_m_addr=0.
- No combinational path from req_m_access to q_m_*.
- A requester dropping req_m_access before its ack is a protocol violation; the scheduler still completes the bus cycle already started.

Test Plan:
- Single request: req 1 raises access at addr 19'h0F000; memory acks 2 cycles later -> q_m_access rises 1 cycle after the request, q_m_addr=19'h0F000, req_m_ack=3'b010 for 1 cycle, q_m_access=0 the following cycle.
- Round-robin: all three request continuously, memory acks every 2nd cycle -> grant order 0,1,2,0,1,2 from reset; no requester is granted twice while another waits.
- Lock: req 0 locked write-then-read while reqs 1 and 2 request -> two consecutive req 0 grants; after lock drops, req 1 granted next.
- Watchdog (TIMEOUT_CYCLES=4): req 2 access, no q_m_ack -> req_m_ack[2] and req_m_err[2] pulse together on the 4th BUSY cycle, data_in=0; pending req 0 granted afterwards.
- Ack on the timeout cycle -> ack only, err=0. Reset asserted mid-BUSY -> all outputs 0 immediately, no ack; first post-reset grant goes to requester 0.
- Write path: req 0 write 16'hA55A, bytesel=2'b01 -> q_m_data_out=16'hA55A, q_m_wr_en=1, q_m_bytesel=2'b01 throughout BUSY.
